pc_sequencer: RTL and testbench

- Control-side counterpart of the PC select mux. Generates the mux's `selection` code and `pc_enable` every cycle.
- Runs the boot sequence: fetches the reset vector from memory and loads the first instruction address.
- Arbitrates branch/call redirects, hazard stalls, halt and interrupt entry.
- Interrupt entry covers pipeline drain, return-address save pulse, interrupt-vector fetch and acknowledge.
- Sits in the fetch stage, between the hazard/branch units and the PC register.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/vec_wait_timer.sv | 31 +++
 rtl/pc_sequencer.sv | 154 +++++++++++++++
 tb/tb_pc_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants for the PC sequencer and the PC select mux it drives.
package pc_pkg;

    // PC mux select codes
    localparam logic [1:0] SEL_NEXT   = 2'b00;
    localparam logic [1:0] SEL_FIRST  = 2'b01;
    localparam logic [1:0] SEL_INT    = 2'b10;
    localparam logic [1:0] SEL_BRANCH = 2'b11;

    // Vector memory select: reset vector at M[0..1], interrupt vector at M[2..3]
    localparam logic VEC_RESET = 1'b0;
    localparam logic VEC_INT   = 1'b1;

    typedef enum logic [2:0] {
        StBoot  = 3'd0,
        StRun   = 3'd1,
        StDrain = 3'd2,
        StVec   = 3'd3,
        StHalt  = 3'd4
    } pc_state_e;

endpackage

// File: rtl/vec_wait_timer.sv
// Wait-cycle counter for vector reads, shared by the boot and interrupt fetches.
module vec_wait_timer #(
    parameter int unsigned VEC_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic timeout
);

    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Count while a read is outstanding; any other cycle (or the timeout itself) restarts at 0
    always_comb begin
        timeout    = run && (wait_cnt_q == 8'(VEC_TIMEOUT - 1));
        wait_cnt_d = 8'd0;
        if (run && !timeout) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Counter register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC control: boot vector load, branch/stall/halt arbitration, interrupt entry.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned VEC_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_req,
    input  logic       branch_taken,
    input  logic       stall,
    input  logic       hlt,
    input  logic       vec_valid,
    output logic [1:0] selection,
    output logic       pc_enable,
    output logic       flush,
    output logic       pc_save,
    output logic       int_ack,
    output logic       vec_req,
    output logic       vec_sel,
    output logic       vec_err
);

    pc_state_e  state_q, state_d;
    logic       int_pending_q, int_pending_d;
    logic       int_req_dly_q;
    logic [3:0] drain_cnt_q, drain_cnt_d;
    logic       vec_err_q, vec_err_d;
    logic       timer_run;
    logic       timer_timeout;

    vec_wait_timer #(
        .VEC_TIMEOUT(VEC_TIMEOUT)
    ) u_vec_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (timer_run),
        .timeout(timer_timeout)
    );

    // Next-state and Mealy outputs; the PC register samples them on the same edge
    always_comb begin
        state_d       = state_q;
        int_pending_d = int_pending_q;
        drain_cnt_d   = drain_cnt_q;
        vec_err_d     = vec_err_q;
        selection     = SEL_NEXT;
        pc_enable     = 1'b0;
        flush         = 1'b0;
        pc_save       = 1'b0;
        int_ack       = 1'b0;
        vec_req       = 1'b0;
        vec_sel       = VEC_RESET;
        vec_err       = vec_err_q;
        timer_run     = 1'b0;

        unique case (state_q)
            StBoot, StVec: begin
                vec_req = 1'b1;
                vec_sel = (state_q == StVec) ? VEC_INT : VEC_RESET;
                if (vec_valid) begin
                    selection = (state_q == StVec) ? SEL_INT : SEL_FIRST;
                    pc_enable = 1'b1;
                    int_ack   = (state_q == StVec);
                    state_d   = StRun;
                end else begin
                    timer_run = 1'b1;
                    if (timer_timeout) begin
                        vec_err_d = 1'b1;
                        state_d   = StHalt;
                    end
                end
            end
            StRun: begin
                // A branch outranks hlt: the hlt sits on the path being flushed
                if (branch_taken) begin
                    selection = SEL_BRANCH;
                    pc_enable = 1'b1;
                    flush     = 1'b1;
                end else if (hlt) begin
                    state_d = StHalt;
                end else if (int_pending_q) begin
                    drain_cnt_d = 4'(DRAIN_CYCLES - 1);
                    state_d     = StDrain;
                end else if (!stall) begin
                    pc_enable = 1'b1;
                end
            end
            StDrain: begin
                // A taken branch refills the pipe, so the drain starts over
                if (branch_taken) begin
                    selection   = SEL_BRANCH;
                    pc_enable   = 1'b1;
                    flush       = 1'b1;
                    drain_cnt_d = 4'(DRAIN_CYCLES - 1);
                end else if (!stall) begin
                    if (drain_cnt_q != 4'd0) begin
                        drain_cnt_d = drain_cnt_q - 4'd1;
                    end else begin
                        pc_save = 1'b1;
                        state_d = StVec;
                    end
                end
            end
            StHalt: begin
                if (int_pending_q && !vec_err_q) begin
                    drain_cnt_d = 4'(DRAIN_CYCLES - 1);
                    state_d     = StDrain;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase

        // New edge beats the acknowledge clear; edges while pending merge into one
        if (int_req && !int_req_dly_q) begin
            int_pending_d = 1'b1;
        end else if (int_ack) begin
            int_pending_d = 1'b0;
        end

        // Quiet outputs while reset is asserted so an aborted entry emits no pulses
        if (!rst) begin
            selection = SEL_NEXT;
            pc_enable = 1'b0;
            flush     = 1'b0;
            pc_save   = 1'b0;
            int_ack   = 1'b0;
            vec_req   = 1'b0;
            vec_sel   = VEC_RESET;
            vec_err   = 1'b0;
        end
    end

    // State registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StBoot;
            int_pending_q <= 1'b0;
            int_req_dly_q <= 1'b0;
            drain_cnt_q   <= 4'd0;
            vec_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            int_pending_q <= int_pending_d;
            int_req_dly_q <= int_req;
            drain_cnt_q   <= drain_cnt_d;
            vec_err_q     <= vec_err_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic vs a reference model.
module tb_pc_sequencer;

    localparam int DRAIN = 3;
    localparam int VTO   = 16;

    // Model phases
    localparam int MB = 0;
    localparam int MR = 1;
    localparam int MD = 2;
    localparam int MV = 3;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       int_req = 1'b0;
    logic       branch_taken = 1'b0;
    logic       stall = 1'b0;
    logic       hlt = 1'b0;
    logic       vec_valid = 1'b0;
    logic [1:0] selection;
    logic       pc_enable;
    logic       flush;
    logic       pc_save;
    logic       int_ack;
    logic       vec_req;
    logic       vec_sel;
    logic       vec_err;

    int total = 0;
    int bad   = 0;

    // Reference model: current and next abstract state
    int   m_mode = MB, n_mode = MB;
    bit   m_pend = 0,  n_pend = 0;
    bit   m_prev = 0,  n_prev = 0;
    int   m_drain = 0, n_drain = 0;
    int   m_wait = 0,  n_wait = 0;
    bit   m_err = 0,   n_err = 0;
    logic [8:0] exp_o;

    wire [8:0] obs = {selection, pc_enable, flush, pc_save, int_ack, vec_req, vec_sel, vec_err};

    pc_sequencer #(
        .DRAIN_CYCLES(DRAIN),
        .VEC_TIMEOUT (VTO)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .int_req     (int_req),
        .branch_taken(branch_taken),
        .stall       (stall),
        .hlt         (hlt),
        .vec_valid   (vec_valid),
        .selection   (selection),
        .pc_enable   (pc_enable),
        .flush       (flush),
        .pc_save     (pc_save),
        .int_ack     (int_ack),
        .vec_req     (vec_req),
        .vec_sel     (vec_sel),
        .vec_err     (vec_err)
    );

    always #5 clk = ~clk;

    // Expected outputs for stimulus s={rst,int_req,branch,stall,hlt,vec_valid}, plus next model state
    task automatic model_eval(input logic [5:0] s);
        logic r, ir, br, st, h, vv;
        logic [1:0] sel;
        logic en, fl, sv, ack, rq, vs;
        {r, ir, br, st, h, vv} = s;
        sel = 2'd0; en = 0; fl = 0; sv = 0; ack = 0; rq = 0; vs = 0;
        n_mode = m_mode; n_pend = m_pend; n_prev = ir;
        n_drain = m_drain; n_wait = m_wait; n_err = m_err;
        if (!r) begin
            n_mode = MB; n_pend = 0; n_prev = 0; n_drain = 0; n_wait = 0; n_err = 0;
            exp_o = 9'd0;
            return;
        end
        case (m_mode)
            MB, MV: begin
                rq = 1;
                vs = (m_mode == MV);
                if (vv) begin
                    en = 1;
                    sel = (m_mode == MV) ? 2'd2 : 2'd1;
                    ack = (m_mode == MV);
                    n_mode = MR;
                    n_wait = 0;
                end else if (m_wait + 1 == VTO) begin
                    n_err = 1;
                    n_mode = MH;
                    n_wait = 0;
                end else begin
                    n_wait = m_wait + 1;
                end
            end
            MR: begin
                if (br) begin
                    sel = 2'd3; en = 1; fl = 1;
                end else if (h) begin
                    n_mode = MH;
                end else if (m_pend) begin
                    n_drain = DRAIN - 1;
                    n_mode = MD;
                end else if (!st) begin
                    en = 1;
                end
            end
            MD: begin
                if (br) begin
                    sel = 2'd3; en = 1; fl = 1;
                    n_drain = DRAIN - 1;
                end else if (!st) begin
                    if (m_drain > 0) begin
                        n_drain = m_drain - 1;
                    end else begin
                        sv = 1;
                        n_wait = 0;
                        n_mode = MV;
                    end
                end
            end
            MH: begin
                if (m_pend && !m_err) begin
                    n_drain = DRAIN - 1;
                    n_mode = MD;
                end
            end
            default: ;
        endcase
        if (ir && !m_prev) n_pend = 1;
        else if (ack) n_pend = 0;
        exp_o = {sel, en, fl, sv, ack, rq, vs, m_err};
    endtask

    // Advance one cycle: commit model, drive at negedge, settle, compute expectation
    task automatic cyc(input logic [5:0] s);
        m_mode = n_mode; m_pend = n_pend; m_prev = n_prev;
        m_drain = n_drain; m_wait = n_wait; m_err = n_err;
        @(negedge clk);
        {rst, int_req, branch_taken, stall, hlt, vec_valid} = s;
        #1;
        model_eval(s);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc({1'b0, 5'($urandom_range(31))});
            total++;
            if (obs !== 9'd0) begin
                bad++;
                $display("FAIL reset cyc%0d got=%b want=%b", i, obs, 9'd0);
            end
        end
    endtask

    task automatic test_boot();
        logic [5:0] stim [6] = '{6'b100000, 6'b100000, 6'b100001, 6'b100000, 6'b100000, 6'b100000};
        for (int i = 0; i < 6; i++) begin
            cyc(stim[i]);
            total++;
            if (obs !== exp_o) begin
                bad++;
                $display("FAIL boot cyc%0d got=%b want=%b", i, obs, exp_o);
            end
        end
        // Third cycle of boot must load the first-instruction address
        cyc(6'b000000);
        cyc(6'b100000);
        cyc(6'b100000);
        cyc(6'b100001);
        total++;
        if ({selection, pc_enable, vec_req, vec_sel} !== 5'b01110) begin
            bad++;
            $display("FAIL boot_first got=%b want=%b", {selection, pc_enable, vec_req, vec_sel},
                     5'b01110);
        end
    endtask

    task automatic test_branch_stall();
        logic [5:0] stim [6] = '{6'b100100, 6'b100100, 6'b101000, 6'b101100, 6'b100000,
                                 6'b101010};
        for (int i = 0; i < 6; i++) begin
            cyc(stim[i]);
            total++;
            if (obs !== exp_o) begin
                bad++;
                $display("FAIL branch_stall cyc%0d got=%b want=%b", i, obs, exp_o);
            end
            if (i == 3) begin
                total++;
                if ({selection, pc_enable, flush} !== 4'b1111) begin
                    bad++;
                    $display("FAIL branch_over_stall got=%b want=1111",
                             {selection, pc_enable, flush});
                end
            end
        end
    endtask

    task automatic test_interrupt();
        logic [5:0] stim [10] = '{6'b100000, 6'b110000, 6'b110000, 6'b110000, 6'b110000,
                                  6'b110000, 6'b110000, 6'b110001, 6'b100000, 6'b100000};
        for (int i = 0; i < 10; i++) begin
            cyc(stim[i]);
            total++;
            if (obs !== exp_o) begin
                bad++;
                $display("FAIL interrupt cyc%0d got=%b want=%b", i, obs, exp_o);
            end
            // Edge at 1, drain entry at 2, save 3 cycles later at 5, ack at 7
            total++;
            if (pc_save !== (i == 5) || int_ack !== (i == 7)) begin
                bad++;
                $display("FAIL int_pulses cyc%0d got=%b%b want=%b%b", i, pc_save, int_ack,
                         i == 5, i == 7);
            end
        end
    endtask

    task automatic test_branch_in_drain();
        logic [5:0] stim [11] = '{6'b100000, 6'b110000, 6'b110000, 6'b110000, 6'b111000,
                                  6'b110000, 6'b110000, 6'b110000, 6'b110000, 6'b110001,
                                  6'b100000};
        for (int i = 0; i < 11; i++) begin
            cyc(stim[i]);
            total++;
            if (obs !== exp_o) begin
                bad++;
                $display("FAIL branch_drain cyc%0d got=%b want=%b", i, obs, exp_o);
            end
            total++;
            if (pc_save !== (i == 7)) begin
                bad++;
                $display("FAIL drain_restart cyc%0d pc_save got=%b want=%b", i, pc_save, i == 7);
            end
        end
    endtask

    task automatic test_halt_wake();
        logic [5:0] stim [12] = '{6'b100010, 6'b100000, 6'b100100, 6'b100000, 6'b110000,
                                  6'b110000, 6'b110000, 6'b110000, 6'b110000, 6'b110000,
                                  6'b110001, 6'b100000};
        for (int i = 0; i < 12; i++) begin
            cyc(stim[i]);
            total++;
            if (obs !== exp_o) begin
                bad++;
                $display("FAIL halt_wake cyc%0d got=%b want=%b", i, obs, exp_o);
            end
        end
    endtask

    task automatic test_timeout();
        cyc(6'b000000);
        for (int i = 0; i < 24; i++) begin
            cyc((i == 18) ? 6'b110000 : 6'b100000);
            total++;
            if (obs !== exp_o) begin
                bad++;
                $display("FAIL timeout cyc%0d got=%b want=%b", i, obs, exp_o);
            end
            total++;
            if (vec_err !== (i >= 16) || (i >= 16 && (pc_enable || pc_save || vec_req))) begin
                bad++;
                $display("FAIL timeout_err cyc%0d err=%b en=%b save=%b req=%b want err=%b", i,
                         vec_err, pc_enable, pc_save, vec_req, i >= 16);
            end
        end
    endtask

    task automatic test_reset_mid_vec();
        logic [5:0] stim [16] = '{6'b000000, 6'b100001, 6'b100000, 6'b110000, 6'b110000,
                                  6'b110000, 6'b110000, 6'b110000, 6'b110000, 6'b010000,
                                  6'b100000, 6'b100001, 6'b100000, 6'b100000, 6'b100000,
                                  6'b100000};
        for (int i = 0; i < 16; i++) begin
            cyc(stim[i]);
            total++;
            if (obs !== exp_o) begin
                bad++;
                $display("FAIL reset_vec cyc%0d got=%b want=%b", i, obs, exp_o);
            end
            if (i >= 9) begin
                total++;
                if (pc_save || int_ack) begin
                    bad++;
                    $display("FAIL reset_vec_pulse cyc%0d save=%b ack=%b want 00", i, pc_save,
                             int_ack);
                end
            end
        end
    endtask

    task automatic test_random();
        logic ir;
        logic [5:0] s;
        ir = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(19) == 0) ir = ~ir;
            s = {($urandom_range(199) != 0), ir, ($urandom_range(7) == 0),
                 ($urandom_range(3) == 0), ($urandom_range(29) == 0), ($urandom_range(2) == 0)};
            cyc(s);
            total++;
            if (obs !== exp_o) begin
                bad++;
                $display("FAIL random cyc%0d stim=%b got=%b want=%b", i, s, obs, exp_o);
            end
            total++;
            if ((!pc_enable && selection != 2'b00) || (flush && selection != 2'b11)) begin
                bad++;
                $display("FAIL invariant cyc%0d got sel=%b en=%b flush=%b", i, selection,
                         pc_enable, flush);
            end
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_branch_stall();
        test_interrupt();
        test_branch_in_drain();
        test_halt_wake();
        test_timeout();
        test_reset_mid_vec();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
